// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator: combinational I/S/B/U/J/zimm decode
// captured into a valid/ready output stage backed by a one-entry skid buffer.
module imm_gen_pipe #(
  parameter int XLEN       = 32,
  parameter int ILEN       = 32,
  parameter int ENABLE_CSR = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;
  logic            s;

  assign s = in_instr[31];

  // Signed size casts sign-extend each raw field up to XLEN.
  always_comb begin
    dec_imm     = '0;
    dec_fmt     = FMT_NONE;
    dec_illegal = 1'b0;
    case (in_instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR: begin
        dec_fmt = FMT_I;
        dec_imm = XLEN'($signed(in_instr[31:20]));
      end
      OP_STORE: begin
        dec_fmt = FMT_S;
        dec_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      end
      OP_BRANCH: begin
        dec_fmt = FMT_B;
        dec_imm = XLEN'($signed({s, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
      end
      OP_LUI, OP_AUIPC: begin
        dec_fmt = FMT_U;
        dec_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
      end
      OP_JAL: begin
        dec_fmt = FMT_J;
        dec_imm = XLEN'($signed({s, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
      end
      OP_SYSTEM: begin
        if ((ENABLE_CSR != 0) && in_instr[14]) begin
          dec_fmt = FMT_Z;
          dec_imm = XLEN'(in_instr[19:15]);
        end
      end
      OP_OP, OP_FENCE: begin
        dec_fmt = FMT_NONE;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Main register (m_*) drives the outputs; skid register (k_*) holds one overflow entry.
  logic            m_valid, k_valid;
  logic [ILEN-1:0] m_instr, k_instr;
  logic [XLEN-1:0] m_imm, k_imm;
  logic [2:0]      m_fmt, k_fmt;
  logic            m_ill, k_ill;
  logic            accept, xfer;

  // valid/ready: a beat moves on a rising clk edge where valid & ready are both 1;
  // in_ready depends only on skid occupancy, so it never combinationally follows out_ready.
  assign in_ready    = ~k_valid;
  assign accept      = in_valid & in_ready;
  assign xfer        = m_valid & out_ready;
  assign out_valid   = m_valid;
  assign out_instr   = m_instr;
  assign out_imm     = m_imm;
  assign out_fmt     = m_fmt;
  assign out_illegal = m_ill;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_instr <= '0;
      m_imm   <= '0;
      m_fmt   <= FMT_NONE;
      m_ill   <= 1'b0;
      k_valid <= 1'b0;
      k_instr <= '0;
      k_imm   <= '0;
      k_fmt   <= FMT_NONE;
      k_ill   <= 1'b0;
    end else if (flush) begin
      m_valid <= 1'b0;
      k_valid <= 1'b0;
    end else if (!m_valid || xfer) begin
      // Skid entry is older than anything on the input, so it refills M first.
      if (k_valid) begin
        m_valid <= 1'b1;
        m_instr <= k_instr;
        m_imm   <= k_imm;
        m_fmt   <= k_fmt;
        m_ill   <= k_ill;
        k_valid <= 1'b0;
      end else if (accept) begin
        m_valid <= 1'b1;
        m_instr <= in_instr;
        m_imm   <= dec_imm;
        m_fmt   <= dec_fmt;
        m_ill   <= dec_illegal;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (accept) begin
      k_valid <= 1'b1;
      k_instr <= in_instr;
      k_imm   <= dec_imm;
      k_fmt   <= dec_fmt;
      k_ill   <= dec_illegal;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: two instances (XLEN=32/CSR on, XLEN=64/CSR off) share
// stimulus; accepted instructions are modelled arithmetically and queued for the monitors.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;

  logic        in_ready_a, out_valid_a, out_illegal_a;
  logic [31:0] out_instr_a, out_imm_a;
  logic [2:0]  out_fmt_a;

  logic        in_ready_b, out_valid_b, out_illegal_b;
  logic [31:0] out_instr_b;
  logic [63:0] out_imm_b;
  logic [2:0]  out_fmt_b;

  int n_vec = 0;
  int n_err = 0;

  // Entry layout: {instr[31:0], imm[63:0], fmt[2:0], illegal}
  logic [99:0] exp_qa[$];
  logic [99:0] exp_qb[$];

  imm_gen_pipe #(.XLEN(32), .ILEN(32), .ENABLE_CSR(1)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_instr(in_instr), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_instr(out_instr_a), .out_imm(out_imm_a), .out_fmt(out_fmt_a),
    .out_illegal(out_illegal_a)
  );

  imm_gen_pipe #(.XLEN(64), .ILEN(32), .ENABLE_CSR(0)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_instr(in_instr), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_instr(out_instr_b), .out_imm(out_imm_b), .out_fmt(out_fmt_b),
    .out_illegal(out_illegal_b)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [99:0] ref_entry(input logic [31:0] ins, input int xlen, input bit csr);
    longint sx, imm;
    logic [2:0] fmt;
    bit ill;
    sx  = longint'($signed(ins));
    imm = 0;
    fmt = 3'd0;
    ill = 1'b0;
    case (ins[6:0])
      7'h13, 7'h03, 7'h67: begin fmt = 3'd1; imm = sx >>> 20; end
      7'h23: begin fmt = 3'd2; imm = ((sx >>> 25) <<< 5) + longint'(ins[11:7]); end
      7'h63: begin
        fmt = 3'd3;
        imm = ((sx >>> 31) <<< 12) + (longint'(ins[7]) << 11)
            + (longint'(ins[30:25]) << 5) + (longint'(ins[11:8]) << 1);
      end
      7'h37, 7'h17: begin fmt = 3'd4; imm = (sx >>> 12) <<< 12; end
      7'h6F: begin
        fmt = 3'd5;
        imm = ((sx >>> 31) <<< 20) + (longint'(ins[19:12]) << 12)
            + (longint'(ins[20]) << 11) + (longint'(ins[30:21]) << 1);
      end
      7'h33, 7'h0F: fmt = 3'd0;
      7'h73: if (csr && ins[14]) begin fmt = 3'd6; imm = longint'(ins[19:15]); end
      default: ill = 1'b1;
    endcase
    if (xlen == 32) imm = imm & 64'h0000_0000_FFFF_FFFF;
    return {ins, 64'(imm), fmt, ill};
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [6:0]  ops [11];
    logic [31:0] r;
    int          k;
    ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F, 7'h73};
    r = $urandom;
    k = $urandom_range(0, 12);
    if (k < 11) r[6:0] = ops[k];
    return r;
  endfunction

  // ---------------- scoreboard: input side ----------------
  initial forever begin
    @(negedge clk);
    #1;
    if (rst === 1'b1 || flush === 1'b1) begin
      exp_qa.delete();
      exp_qb.delete();
    end else if (in_valid === 1'b1 && in_ready_a === 1'b1) begin
      exp_qa.push_back(ref_entry(in_instr, 32, 1'b1));
      exp_qb.push_back(ref_entry(in_instr, 64, 1'b0));
    end
  end

  // ---------------- monitors ----------------
  initial forever begin
    logic [99:0] e;
    @(negedge clk);
    if (out_valid_a === 1'b1) begin
      if (exp_qa.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL a_unexpected: output instr %h with no expected entry", out_instr_a);
      end else begin
        e = exp_qa[0];
        check("a_instr", 64'(out_instr_a), 64'(e[99:68]));
        check("a_imm", 64'(out_imm_a), e[67:4]);
        check("a_fmt", 64'(out_fmt_a), 64'(e[3:1]));
        check("a_illegal", 64'(out_illegal_a), 64'(e[0]));
        if (out_ready === 1'b1) void'(exp_qa.pop_front());
      end
    end
  end

  initial forever begin
    logic [99:0] e;
    @(negedge clk);
    if (out_valid_b === 1'b1) begin
      if (exp_qb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL b_unexpected: output instr %h with no expected entry", out_instr_b);
      end else begin
        e = exp_qb[0];
        check("b_instr", 64'(out_instr_b), 64'(e[99:68]));
        check("b_imm", out_imm_b, e[67:4]);
        check("b_fmt", 64'(out_fmt_b), 64'(e[3:1]));
        check("b_illegal", 64'(out_illegal_b), 64'(e[0]));
        if (out_ready === 1'b1) void'(exp_qb.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_instr = ins;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      done = in_ready_a;
      tick();
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: instr %h never accepted", ins);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out_valid_a"}, 64'(out_valid_a), 64'd0);
    check({tag, "_in_ready_a"}, 64'(in_ready_a), 64'd1);
    check({tag, "_out_imm_a"}, 64'(out_imm_a), 64'd0);
    check({tag, "_out_instr_a"}, 64'(out_instr_a), 64'd0);
    check({tag, "_out_fmt_a"}, 64'(out_fmt_a), 64'd0);
    check({tag, "_out_illegal_a"}, 64'(out_illegal_a), 64'd0);
    check({tag, "_out_valid_b"}, 64'(out_valid_b), 64'd0);
    check({tag, "_in_ready_b"}, 64'(in_ready_b), 64'd1);
    check({tag, "_out_imm_b"}, out_imm_b, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] t_ins  [9];
    logic [31:0] t_imma [9];
    logic [63:0] t_immb [9];
    logic [2:0]  t_fmta [9];
    logic [2:0]  t_fmtb [9];
    logic        t_ill  [9];
    bit          acc;

    t_ins  = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000CE3, 32'h123452B7, 32'h0010006F,
               32'h800002B7, 32'h0000007F, 32'h0007D073, 32'h00000033};
    t_imma = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'h00000800,
               32'h80000000, 32'h00000000, 32'h0000000F, 32'h00000000};
    t_immb = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8,
               64'h0000000012345000, 64'h0000000000000800, 64'hFFFFFFFF80000000,
               64'h0, 64'h0, 64'h0};
    t_fmta = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd4, 3'd0, 3'd6, 3'd0};
    t_fmtb = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd4, 3'd0, 3'd0, 3'd0};
    t_ill  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
    repeat (3) tick();
    rst = 1'b0;
    check_idle("reset");

    // Directed decode, continuous flow: each result must appear the cycle after accept.
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_instr = t_ins[i];
      tick();
      check("dir_valid", 64'(out_valid_a), 64'd1);
      check("dir_instr", 64'(out_instr_a), 64'(t_ins[i]));
      check("dir_imm32", 64'(out_imm_a), 64'(t_imma[i]));
      check("dir_fmt32", 64'(out_fmt_a), 64'(t_fmta[i]));
      check("dir_ill32", 64'(out_illegal_a), 64'(t_ill[i]));
      check("dir_imm64", out_imm_b, t_immb[i]);
      check("dir_fmt64", 64'(out_fmt_b), 64'(t_fmtb[i]));
    end
    in_valid = 1'b0;
    repeat (2) tick();

    // Backpressure: two accepts fill M and K, then in_ready must drop.
    out_ready = 1'b0;
    send(32'h00500113);
    send(32'hFFF1A203);
    check("bp_in_ready", 64'(in_ready_a), 64'd0);
    check("bp_out_valid", 64'(out_valid_a), 64'd1);
    in_instr = 32'h00C0006F;
    tick();
    check("bp_hold_ready", 64'(in_ready_a), 64'd0);
    check("bp_hold_instr", 64'(out_instr_a), 64'h00500113);
    out_ready = 1'b1;
    send(32'h00C0006F);
    send(32'hABCDE0B7);
    in_valid = 1'b0;
    repeat (4) tick();

    // Flush with M and K full, plus a same-cycle input that must vanish.
    out_ready = 1'b0;
    send(32'h00100093);
    send(32'h00200093);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h00300093;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", 64'(out_valid_a), 64'd0);
    check("flush_in_ready", 64'(in_ready_a), 64'd1);
    out_ready = 1'b1;
    repeat (3) tick();

    // Reset while stalled with two entries held.
    out_ready = 1'b0;
    send(32'hFFF00093);
    send(32'hFE000CE3);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("midrst");

    // Randomised valid/ready/flush traffic; a pending input is held until accepted.
    in_valid = 1'b0;
    in_instr = gen_instr();
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready_a;
      tick();
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      if (!in_valid || acc) begin
        in_valid = 1'($urandom_range(0, 1));
        in_instr = gen_instr();
      end
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (exp_qa.size() != 0 || exp_qb.size() != 0); c++) tick();
    tick();
    check("drain_a_empty", 64'(exp_qa.size()), 64'd0);
    check("drain_b_empty", 64'(exp_qb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Registered, parametrised RISC-V immediate generator for the decode stage, successor to the combinational single-cycle generator.
- Decodes every base immediate format: I, S, B, U, J, plus the optional CSR zimm.
- Sign-extends to XLEN (32 or 64).
- Flags illegal or non-immediate opcodes.
- Wraps the decode in a valid/ready pipeline stage with a one-entry skid buffer, so fetch and execute can stall independently.

Parameters:
XLEN, 32, output immediate width; legal values 32 or 64.
ILEN, 32, instruction width; fixed at 32, other values are illegal.
ENABLE_CSR, 1, if 1 decode SYSTEM CSR*I zimm; if 0 treat opcode 1110011 as no-immediate.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  synchronous, active-high reset.
flush  in  1  synchronous pipeline flush; drops all held entries.
in_valid  in  1  instruction presented.
in_ready  out  1  stage can accept; registered.
in_instr  in  ILEN  raw instruction word.
out_valid  out  1  decoded entry available.
out_ready  in  1  downstream accepts.
out_instr  out  ILEN  instruction passed through, aligned with immediate.
out_imm  out  XLEN  sign-extended immediate.
out_fmt  out  3  0=NONE, 1=I, 2=S, 3=B, 4=U, 5=J, 6=Z (zimm).
out_illegal  out  1  opcode[1:0]!=11 or opcode not in the supported set.

Behaviour:
- Opcode map, instr[6:0]:
  - I: 0010011, 0000011, 1100111.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - NONE, legal: 0110011, 0001111.
  - SYSTEM 1110011: with ENABLE_CSR=1 and funct3[2]=1 → Z; all other cases → NONE.
  - Anything else → NONE with out_illegal=1.
- Immediate formation; s = instr[31]; sign-extension always fills to XLEN.
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({s, instr[7], instr[30:25], instr[11:8], 0}).
  - U: sext({instr[31:12], 12'b0}); with XLEN=64, bits 63:32 = s.
  - J: sext({s, instr[19:12], instr[20], instr[30:21], 0}).
  - Z: zero-extended instr[19:15].
  - NONE/illegal: 0.
- Storage:
  - Main output register (M) drives the out_* ports.
  - Skid register (K) has the same fields.
  - Decode is combinational from in_instr; the decoded result is captured on accept.
- Handshake:
  - Input accept = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - in_ready = !K.valid, registered.
  - out_valid = M.valid.
  - Latency: accept in cycle N → out_valid in N+1 when M is free or draining.
- Transitions each cycle, after transfer is evaluated:
  - M empty or transferring, K empty: accept loads M.
  - M full and not transferring, K empty: accept loads K; in_ready drops next cycle.
  - M transferring, K full: K moves to M, K clears, in_ready rises next cycle.
  - Ordering is strictly FIFO; no entry is lost or duplicated.
- out_* payload is held stable while out_valid=1 and out_ready=0.
- Priority: rst > flush > normal operation.
  - flush clears M.valid and K.valid; any same-cycle accept is discarded.
  - in_ready=1 in the cycle after flush.
- Reset values: out_valid=0, out_imm=0, out_instr=0, out_fmt=0, out_illegal=0, K cleared, in_ready=1.
  - Reset mid-stall drops both entries.
- Throughput: 1 instruction/cycle with out_ready held high.

Test Plan:
1. Format decode, XLEN=32, continuous flow:
   - 0xFFF00093 (addi x1,x0,-1) → out_imm 0xFFFFFFFF, fmt 1, next cycle.
   - 0xFE20AE23 (sw, -4) → 0xFFFFFFFC, fmt 2.
   - 0xFE000CE3 (beq, -8) → 0xFFFFFFF8, fmt 3.
   - 0x123452B7 (lui) → 0x12345000, fmt 4.
   - 0x0010006F (jal, +2048) → 0x00000800, fmt 5.
2. XLEN=64: 0xFFF00093 → 0xFFFFFFFFFFFFFFFF; 0x800002B7 (lui 0x80000) → 0xFFFFFFFF80000000.
3. Illegal and CSR decode:
   - 0x0000007F → out_illegal=1, imm 0, fmt 0.
   - 0x0007D073 (csrrwi, zimm=15) → imm 0x0000000F, fmt 6 when ENABLE_CSR=1; fmt 0 when ENABLE_CSR=0.
4. Backpressure:
   - Stream 4 instructions with out_ready=0 for 3 cycles.
   - Required: in_ready falls after 2 accepts and outputs stay stable.
   - Releasing out_ready yields all 4 in order with no drop or duplicate.
5. Flush with M and K full → next cycle out_valid=0, in_ready=1. Flush plus in_valid in the same cycle → that instruction is never output.
6. Assert rst while stalled with 2 entries held → all outputs 0 and in_ready=1 next cycle. Randomised valid/ready for 1000 cycles against a reference queue model → no mismatches.
